conv1_mac_array: RTL and testbench
==================================

# conv1_mac_array

Convolution engine for layer 1: the responder side of the convoluter handshake driven by the conv1 pooling controller. It accepts one 6×6 feature-map tile (`im`), one 5×5 kernel (`iw`) and a bias (`ib`). It computes the four overlapping 5×5 convolutions (a 2×2 output patch) with four parallel MACs over 25 cycles. The results are returned as four signed halfwords with `convResVld`, which is held until the controller releases `imVld`.

## Interface
Parameters (widths below assume defaults; only defaults are verified):
- `DATA_SIZE`, 8, element width (signed two's complement)
- `OUT_W`, 16, result width
- `BIAS_SHIFT`, 0, left shift applied to sign-extended bias before adding

Ports. One clock; reset is asynchronous and active-high.
- `clk` in 1: clock
- `rst` in 1: asynchronous, active-high reset
- `iwVld` in 1: weights and bias valid (level)
- `imVld` in 1: map tile valid (level); starts a computation
- `im` in 288: 6×6 tile; byte k (k=0..35) is `im[287-8k -: 8]`, row k/6, col k%6
- `iw` in 200: 5×5 kernel; byte j (j=0..24) is `iw[199-8j -: 8]`, row j/5, col j%5
- `ib` in 8: signed bias
- `convResVld` out 1: results valid (level)
- `conv1_num1` out 16: output at tile offset (0,0)
- `conv1_num2` out 16: output at tile offset (0,1)
- `conv1_num3` out 16: output at tile offset (1,0)
- `conv1_num4` out 16: output at tile offset (1,1)

## Operation
- Definition: `num(r,c) = sat16( Σ_{kr,kc=0..4} map[r+kr][c+kc]·w[kr][kc] + (sext(ib) <<< BIAS_SHIFT) )`.
- Products are 16-bit signed. Accumulators are 22-bit signed; no internal overflow is possible.
- `sat16` clamps to the range [-32768, 32767].
- FSM states are IDLE, CALC and DONE.
- IDLE:
  - If `imVld`=1 and `iwVld`=1, latch `im`, `iw` and `ib` into internal registers, clear the accumulators, set tap=0, and go to CALC.
  - `imVld`=1 with `iwVld`=0 is ignored; the block stays in IDLE.
- CALC:
  - Each cycle, each of the four MACs adds the product of the map byte at (r+tap/5, c+tap%5) and kernel byte `tap`. Then tap increments.
  - After tap 24, add the bias, saturate, register all four outputs, assert `convResVld`, and go to DONE.
  - If `imVld` is sampled 0 during CALC, abort: go to IDLE with no result. `convResVld` stays 0 and the outputs keep their previous values.
- DONE:
  - `convResVld`=1 and all four outputs are held stable while `imVld`=1, for any duration.
  - When `imVld` is sampled 0, deassert `convResVld` and go to IDLE.
- Input changes to `im`, `iw` or `ib` after the latch cycle have no effect on the current result.
- `iwVld` dropping during CALC or DONE has no effect.
- Outputs retain the last result after `convResVld` falls, until the next result is registered.

## Timing
- Reset values: `convResVld`=0 and `conv1_num1..4`=0. The FSM goes to IDLE and the accumulators and tap counter are cleared.
- Reset asserted mid-CALC or mid-DONE returns the block to these values immediately; no result is produced.
- Latency:
  - Edge E0 samples `imVld`=1 in IDLE (latch).
  - Edges E1..E25 accumulate taps 0..24.
  - `convResVld` is high after edge E26.
- `convResVld` falls on the first edge that samples `imVld`=0 in DONE.
- A new start needs `imVld` to have been sampled 0 at least once. Holding `imVld` high never retriggers a computation.
- Back-to-back operation: `imVld` low for one edge, then high again, starts a new computation one edge after the return to IDLE.

## Test plan
- **All ones:** tile all 1, kernel all 1, `ib`=0 → after 26 edges `convResVld`=1 and num1..4 = 25.
- **Positional:** tile byte k = k, kernel tap0=1 and all others 0, `ib`=3 → num1=3, num2=4, num3=9, num4=10.
- **Saturation:**
  - tile all 127, kernel all 127, `ib`=127 → all outputs 32767.
  - tile all 127, kernel all -128 (0x80) → all outputs -32768.
- **Hold and release:** keep `imVld` high for 40 cycles after `convResVld` while toggling `im`, `iw` and `ib` → outputs are unchanged and `convResVld` stays 1. Drop `imVld` → `convResVld`=0 on the next edge. Re-raise `imVld` → a fresh result 26 edges later.
- **Abort:** drop `imVld` at E10 of CALC → `convResVld` is never asserted and the outputs keep their old values. Raise `imVld` with `iwVld`=0 → no start.
- **Reset mid-CALC** at E12 → `convResVld`=0 and outputs are 0 immediately. After release, a normal run completes with correct values.

Source files
------------

// File: rtl/conv1_mac_array.sv
// Layer-1 convolution responder: latches a 6x6 tile, a 5x5 kernel and a bias, then runs
// four parallel MACs over 25 taps to produce a saturated 2x2 output patch.

module conv1_mac_lane #(
  parameter int DATA_SIZE = 8,
  parameter int ACC_W     = 22
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clr_i,
  input  logic                        en_i,
  input  logic signed [DATA_SIZE-1:0] a_i,
  input  logic signed [DATA_SIZE-1:0] b_i,
  output logic signed [ACC_W-1:0]     acc_o
);
  localparam int PW = 2 * DATA_SIZE;

  logic signed [PW-1:0]    prod;
  logic signed [ACC_W-1:0] acc_q, acc_d;

  assign prod = PW'(a_i) * PW'(b_i);

  always_comb begin
    acc_d = acc_q;
    if (clr_i)     acc_d = '0;
    else if (en_i) acc_d = acc_q + ACC_W'(prod);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) acc_q <= '0;
    else     acc_q <= acc_d;
  end

  assign acc_o = acc_q;
endmodule

module conv1_mac_array #(
  parameter int DATA_SIZE  = 8,
  parameter int OUT_W      = 16,
  parameter int BIAS_SHIFT = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   iwVld,
  input  logic                   imVld,
  input  logic [36*DATA_SIZE-1:0] im,
  input  logic [25*DATA_SIZE-1:0] iw,
  input  logic [DATA_SIZE-1:0]   ib,
  output logic                   convResVld,
  output logic [OUT_W-1:0]       conv1_num1,
  output logic [OUT_W-1:0]       conv1_num2,
  output logic [OUT_W-1:0]       conv1_num3,
  output logic [OUT_W-1:0]       conv1_num4
);
  localparam int NUM_LANES = 4;
  localparam int MAP_DIM   = 6;
  localparam int K_DIM     = 5;
  localparam int MAP_N     = MAP_DIM * MAP_DIM;
  localparam int TAPS      = K_DIM * K_DIM;
  localparam int ACC_W     = 22;
  localparam int SUM_W     = ACC_W + BIAS_SHIFT + 2;
  localparam logic signed [SUM_W-1:0] MAXV = SUM_W'((1 <<< (OUT_W - 1)) - 1);
  localparam logic signed [SUM_W-1:0] MINV = -MAXV - SUM_W'(1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e                               state_q, state_d;
  logic [4:0]                           tap_q, tap_d;
  logic [2:0]                           kr_q, kr_d, kc_q, kc_d;
  logic                                 vld_q, vld_d;
  logic [NUM_LANES-1:0][OUT_W-1:0]      res_q, res_d;
  // Packed so that byte 0 (first on the bus) lands in the top element: byte k = map_q[MAP_N-1-k].
  logic [MAP_N-1:0][DATA_SIZE-1:0]      map_q;
  logic [TAPS-1:0][DATA_SIZE-1:0]       w_q;
  logic signed [DATA_SIZE-1:0]          b_q;
  logic                                 latch, acc_en;
  logic [NUM_LANES-1:0][ACC_W-1:0]      acc;
  logic [NUM_LANES-1:0][OUT_W-1:0]      sat;
  logic [4:0]                           widx;

  assign widx = 5'(TAPS - 1 - int'(tap_q));

  for (genvar n = 0; n < NUM_LANES; n++) begin : g_lane
    localparam int LR = n / 2;
    localparam int LC = n % 2;
    logic [5:0]              midx;
    logic signed [SUM_W-1:0] sum;

    assign midx = 6'(MAP_N - 1 - ((LR + int'(kr_q)) * MAP_DIM + LC + int'(kc_q)));

    conv1_mac_lane #(.DATA_SIZE(DATA_SIZE), .ACC_W(ACC_W)) u_mac (
      .clk   (clk),
      .rst   (rst),
      .clr_i (latch),
      .en_i  (acc_en),
      .a_i   (map_q[midx]),
      .b_i   (w_q[widx]),
      .acc_o (acc[n])
    );

    assign sum    = SUM_W'($signed(acc[n])) + (SUM_W'(b_q) <<< BIAS_SHIFT);
    assign sat[n] = (sum > MAXV) ? OUT_W'(MAXV) :
                    (sum < MINV) ? OUT_W'(MINV) : OUT_W'(sum);
  end

  always_comb begin
    state_d = state_q;
    tap_d   = tap_q;
    kr_d    = kr_q;
    kc_d    = kc_q;
    vld_d   = vld_q;
    res_d   = res_q;
    latch   = 1'b0;
    acc_en  = 1'b0;
    case (state_q)
      IDLE: begin
        if (imVld && iwVld) begin
          latch   = 1'b1;
          tap_d   = '0;
          kr_d    = '0;
          kc_d    = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        // Controller withdrawing imVld aborts silently; old results stay on the outputs.
        if (!imVld) begin
          state_d = IDLE;
        end else if (int'(tap_q) == TAPS) begin
          res_d   = sat;
          vld_d   = 1'b1;
          state_d = DONE;
        end else begin
          acc_en = 1'b1;
          tap_d  = tap_q + 5'd1;
          if (int'(kc_q) == K_DIM - 1) begin
            kc_d = '0;
            kr_d = kr_q + 3'd1;
          end else begin
            kc_d = kc_q + 3'd1;
          end
        end
      end
      DONE: begin
        if (!imVld) begin
          vld_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      tap_q   <= '0;
      kr_q    <= '0;
      kc_q    <= '0;
      vld_q   <= 1'b0;
      res_q   <= '0;
      map_q   <= '0;
      w_q     <= '0;
      b_q     <= '0;
    end else begin
      state_q <= state_d;
      tap_q   <= tap_d;
      kr_q    <= kr_d;
      kc_q    <= kc_d;
      vld_q   <= vld_d;
      res_q   <= res_d;
      if (latch) begin
        map_q <= im;
        w_q   <= iw;
        b_q   <= ib;
      end
    end
  end

  assign convResVld = vld_q;
  assign conv1_num1 = res_q[0];
  assign conv1_num2 = res_q[1];
  assign conv1_num3 = res_q[2];
  assign conv1_num4 = res_q[3];
endmodule

// File: tb/tb_conv1_mac_array.sv
// Directed + randomized bench for conv1_mac_array; expected patches come from a plain
// arithmetic convolution of the tile/kernel arrays held here.

module tb_conv1_mac_array;
  logic         clk = 1'b0;
  logic         rst;
  logic         iwVld, imVld;
  logic [287:0] im;
  logic [199:0] iw;
  logic [7:0]   ib;
  logic         convResVld;
  logic [15:0]  conv1_num1, conv1_num2, conv1_num3, conv1_num4;

  conv1_mac_array dut (
    .clk        (clk),
    .rst        (rst),
    .iwVld      (iwVld),
    .imVld      (imVld),
    .im         (im),
    .iw         (iw),
    .ib         (ib),
    .convResVld (convResVld),
    .conv1_num1 (conv1_num1),
    .conv1_num2 (conv1_num2),
    .conv1_num3 (conv1_num3),
    .conv1_num4 (conv1_num4)
  );

  always #5 clk = ~clk;

  int tile[36];
  int kern[25];
  int bias;
  int expv[4];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int sat16(input int v);
    if (v > 32767)  return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  // Output (r,c) of the 2x2 patch is the 5x5 window anchored at tile row r, col c.
  task automatic model();
    for (int n = 0; n < 4; n++) begin
      int s;
      s = bias;
      for (int kr = 0; kr < 5; kr++)
        for (int kc = 0; kc < 5; kc++)
          s += tile[(n / 2 + kr) * 6 + (n % 2) + kc] * kern[kr * 5 + kc];
      expv[n] = sat16(s);
    end
  endtask

  task automatic apply();
    for (int k = 0; k < 36; k++) im[287 - 8 * k -: 8] = 8'(tile[k]);
    for (int j = 0; j < 25; j++) iw[199 - 8 * j -: 8] = 8'(kern[j]);
    ib = 8'(bias);
  endtask

  task automatic rand_fill(input int lo, input int hi);
    for (int k = 0; k < 36; k++) tile[k] = int'($urandom_range(0, hi - lo)) + lo;
    for (int j = 0; j < 25; j++) kern[j] = int'($urandom_range(0, hi - lo)) + lo;
    bias = int'($urandom_range(0, 255)) - 128;
  endtask

  task automatic chk_outs(input string tag);
    chk({tag, ".num1"}, longint'($signed(conv1_num1)), expv[0]);
    chk({tag, ".num2"}, longint'($signed(conv1_num2)), expv[1]);
    chk({tag, ".num3"}, longint'($signed(conv1_num3)), expv[2]);
    chk({tag, ".num4"}, longint'($signed(conv1_num4)), expv[3]);
  endtask

  // Assumes the DUT is idle; counts edges from the latch edge (E0) until convResVld.
  task automatic run_check(input string tag);
    int lat;
    lat = 0;
    model();
    apply();
    iwVld = 1'b1;
    imVld = 1'b1;
    for (int c = 1; c <= 60; c++) begin
      @(posedge clk); #1;
      if (convResVld) begin
        lat = c;
        break;
      end
    end
    chk({tag, ".latency"}, lat, 27);
    chk_outs(tag);
  endtask

  task automatic release_imvld(input string tag);
    imVld = 1'b0;
    @(posedge clk); #1;
    chk({tag, ".vld_fall"}, convResVld, 0);
    chk_outs({tag, ".retain"});
  endtask

  initial begin
    int seen;
    int hold_ok;
    rst = 1'b1; iwVld = 1'b0; imVld = 1'b0; im = '0; iw = '0; ib = '0;
    repeat (2) @(posedge clk);
    #1;
    expv = '{0, 0, 0, 0};
    chk("reset.vld", convResVld, 0);
    chk_outs("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // All ones
    foreach (tile[k]) tile[k] = 1;
    foreach (kern[j]) kern[j] = 1;
    bias = 0;
    run_check("ones");
    release_imvld("ones");

    // Positional: only tap 0 contributes
    foreach (tile[k]) tile[k] = k;
    foreach (kern[j]) kern[j] = (j == 0) ? 1 : 0;
    bias = 3;
    run_check("pos");
    release_imvld("pos");

    // Saturation both ways
    foreach (tile[k]) tile[k] = 127;
    foreach (kern[j]) kern[j] = 127;
    bias = 127;
    run_check("sat_hi");
    release_imvld("sat_hi");
    foreach (kern[j]) kern[j] = -128;
    bias = 0;
    run_check("sat_lo");
    release_imvld("sat_lo");

    // Randomized: small values (no saturation) and full range
    for (int i = 0; i < 4; i++) begin
      rand_fill(-8, 7);
      run_check($sformatf("rnd_small%0d", i));
      release_imvld($sformatf("rnd_small%0d", i));
    end
    for (int i = 0; i < 4; i++) begin
      rand_fill(-128, 127);
      run_check($sformatf("rnd_full%0d", i));
      release_imvld($sformatf("rnd_full%0d", i));
    end

    // Hold while inputs churn, then release and back-to-back restart
    rand_fill(-16, 15);
    run_check("hold");
    hold_ok = 0;
    for (int i = 0; i < 40; i++) begin
      im = {9{$urandom()}};
      iw = {7{$urandom()}};
      ib = 8'($urandom());
      iwVld = 1'($urandom());
      @(posedge clk); #1;
      if (convResVld && $signed(conv1_num1) == expv[0] && $signed(conv1_num2) == expv[1] &&
          $signed(conv1_num3) == expv[2] && $signed(conv1_num4) == expv[3]) hold_ok++;
    end
    chk("hold.stable_cycles", hold_ok, 40);
    release_imvld("hold");
    rand_fill(-128, 127);
    run_check("b2b");
    release_imvld("b2b");

    // Abort at E10: no result, old outputs kept
    rand_fill(-128, 127);
    apply();
    iwVld = 1'b1;
    imVld = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    imVld = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (convResVld) seen++;
    end
    chk("abort.vld_seen", seen, 0);
    chk_outs("abort.keep");
    iwVld = 1'b0;
    imVld = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (convResVld) seen++;
    end
    chk("no_iw.vld_seen", seen, 0);
    imVld = 1'b0;
    @(posedge clk); #1;
    rand_fill(-128, 127);
    run_check("post_abort");
    release_imvld("post_abort");

    // Asynchronous reset between E11 and E12
    rand_fill(-128, 127);
    apply();
    iwVld = 1'b1;
    imVld = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    expv = '{0, 0, 0, 0};
    chk("rst_mid.vld", convResVld, 0);
    chk_outs("rst_mid");
    @(posedge clk); #1;
    rst = 1'b0;
    imVld = 1'b0;
    @(posedge clk); #1;
    rand_fill(-128, 127);
    run_check("post_rst");
    release_imvld("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
